// File: rtl/counter_bank.sv
// Bank of independent prescaled up/down counters with one-shot or auto-reload
// behaviour, per-channel terminal-count strobe and sticky interrupt flag.
module counter_bank #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned PRESC_W = 8,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [WIDTH-1:0]        cfg_reload,
  input  logic [PRESC_W-1:0]      cfg_presc,
  input  logic [2:0]              cfg_mode,
  input  logic [NUM_CH-1:0]       irq_clr,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       tc_pulse,
  output logic [NUM_CH-1:0]       irq,
  output logic [NUM_CH-1:0]       active
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state  [NUM_CH];
  logic [WIDTH-1:0]     cnt    [NUM_CH];
  logic [WIDTH-1:0]     reload [NUM_CH];
  logic [PRESC_W-1:0]   presc  [NUM_CH];
  logic [PRESC_W-1:0]   p      [NUM_CH];
  logic [2:0]           mode   [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_count
    assign count[g*WIDTH +: WIDTH] = cnt[g];
  end

  // mode[0]=up, mode[1]=auto-reload, mode[2]=enable; an out-of-range cfg_ch matches no channel
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        state[i]    <= IDLE;
        cnt[i]      <= '0;
        reload[i]   <= '0;
        presc[i]    <= '0;
        p[i]        <= '0;
        mode[i]     <= '0;
        tc_pulse[i] <= 1'b0;
        irq[i]      <= 1'b0;
        active[i]   <= 1'b0;
      end else if (cfg_we && (cfg_ch == CH_W'(i))) begin
        // Configuration overrides any tick on this channel in the same cycle
        reload[i]   <= cfg_reload;
        presc[i]    <= cfg_presc;
        mode[i]     <= cfg_mode;
        cnt[i]      <= cfg_mode[0] ? '0 : cfg_reload;
        p[i]        <= '0;
        tc_pulse[i] <= 1'b0;
        state[i]    <= cfg_mode[2] ? RUN : IDLE;
        active[i]   <= cfg_mode[2];
        if (irq_clr[i]) irq[i] <= 1'b0;
      end else begin
        tc_pulse[i] <= 1'b0;
        if (irq_clr[i]) irq[i] <= 1'b0;
        if (state[i] == RUN) begin
          if (p[i] == presc[i]) begin
            p[i] <= '0;
            if (cnt[i] == (mode[i][0] ? reload[i] : '0)) begin
              // Terminal tick: set takes priority over a simultaneous clear
              tc_pulse[i] <= 1'b1;
              irq[i]      <= 1'b1;
              if (mode[i][1]) begin
                cnt[i] <= mode[i][0] ? '0 : reload[i];
              end else begin
                state[i]  <= DONE;
                active[i] <= 1'b0;
              end
            end else begin
              cnt[i] <= mode[i][0] ? cnt[i] + WIDTH'(1) : cnt[i] - WIDTH'(1);
            end
          end else begin
            p[i] <= p[i] + PRESC_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_bank.sv
// Directed self-checking bench for counter_bank (WIDTH=8, NUM_CH=3, PRESC_W=8).
module tb_counter_bank;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned NUM_CH  = 3;
  localparam int unsigned PRESC_W = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    cfg_we;
  logic [1:0]              cfg_ch;
  logic [WIDTH-1:0]        cfg_reload;
  logic [PRESC_W-1:0]      cfg_presc;
  logic [2:0]              cfg_mode;
  logic [NUM_CH-1:0]       irq_clr;
  logic [NUM_CH*WIDTH-1:0] count;
  logic [NUM_CH-1:0]       tc_pulse;
  logic [NUM_CH-1:0]       irq;
  logic [NUM_CH-1:0]       active;

  int n_cmp = 0;
  int n_err = 0;

  counter_bank #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .PRESC_W(PRESC_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_reload(cfg_reload), .cfg_presc(cfg_presc), .cfg_mode(cfg_mode),
    .irq_clr(irq_clr), .count(count), .tc_pulse(tc_pulse), .irq(irq),
    .active(active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       we;
    logic [1:0] ch;
    logic [7:0] reload;
    logic [7:0] presc;
    logic [2:0] mode;
    logic [2:0] clr;
    int         n;
    int         cc;
    logic [7:0] cnt;
    logic [2:0] tc;
    logic [2:0] irq;
    logic [2:0] act;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic w, logic [1:0] c, logic [7:0] rl, logic [7:0] ps,
                              logic [2:0] md, logic [2:0] cl, int n, int cc, logic [7:0] ec,
                              logic [2:0] et, logic [2:0] ei, logic [2:0] ea);
    vec_t v;
    v.rst = r; v.we = w; v.ch = c; v.reload = rl; v.presc = ps; v.mode = md; v.clr = cl;
    v.n = n; v.cc = cc; v.cnt = ec; v.tc = et; v.irq = ei; v.act = ea;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] cnt_of(int c);
    return count[c*WIDTH +: WIDTH];
  endfunction

  // Drive one cycle of inputs, let the edge pass, then return inputs to idle
  task automatic cyc(logic r, logic w, logic [1:0] c, logic [7:0] rl, logic [7:0] ps,
                     logic [2:0] md, logic [2:0] cl);
    rst = r; cfg_we = w; cfg_ch = c; cfg_reload = rl; cfg_presc = ps; cfg_mode = md; irq_clr = cl;
    @(posedge clk);
    #1;
    rst = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_reload = '0; cfg_presc = '0; cfg_mode = '0;
    irq_clr = '0;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_reload = '0; cfg_presc = '0; cfg_mode = '0;
    irq_clr = '0;

    // rst we ch reload presc mode clr | n chk_ch cnt tc irq act
    vq.push_back(mk(1, 0, 0, 0, 0, 3'b000, 3'b000, 1, 0, 8'd0, 3'b000, 3'b000, 3'b000));
    vq.push_back(mk(0, 1, 0, 3, 0, 3'b111, 3'b000, 1, 0, 8'd0, 3'b000, 3'b000, 3'b001));
    vq.push_back(mk(0, 0, 0, 0, 0, 3'b000, 3'b000, 3, 0, 8'd3, 3'b000, 3'b000, 3'b001));
    vq.push_back(mk(0, 0, 0, 0, 0, 3'b000, 3'b000, 1, 0, 8'd0, 3'b001, 3'b001, 3'b001));
    vq.push_back(mk(0, 0, 0, 0, 0, 3'b000, 3'b000, 1, 0, 8'd1, 3'b000, 3'b001, 3'b001));
    vq.push_back(mk(0, 0, 0, 0, 0, 3'b000, 3'b000, 2, 0, 8'd3, 3'b000, 3'b001, 3'b001));
    vq.push_back(mk(0, 0, 0, 0, 0, 3'b000, 3'b000, 1, 0, 8'd0, 3'b001, 3'b001, 3'b001));
    vq.push_back(mk(0, 0, 0, 0, 0, 3'b000, 3'b000, 3, 0, 8'd3, 3'b000, 3'b001, 3'b001));
    vq.push_back(mk(0, 0, 0, 0, 0, 3'b000, 3'b001, 1, 0, 8'd0, 3'b001, 3'b001, 3'b001));
    vq.push_back(mk(0, 0, 0, 0, 0, 3'b000, 3'b001, 1, 0, 8'd1, 3'b000, 3'b000, 3'b001));
    vq.push_back(mk(0, 1, 0, 0, 0, 3'b000, 3'b000, 1, 0, 8'd0, 3'b000, 3'b000, 3'b000));
    vq.push_back(mk(0, 1, 1, 5, 2, 3'b100, 3'b000, 1, 1, 8'd5, 3'b000, 3'b000, 3'b010));
    vq.push_back(mk(0, 0, 0, 0, 0, 3'b000, 3'b000, 2, 1, 8'd5, 3'b000, 3'b000, 3'b010));
    vq.push_back(mk(0, 0, 0, 0, 0, 3'b000, 3'b000, 1, 1, 8'd4, 3'b000, 3'b000, 3'b010));
    vq.push_back(mk(0, 0, 0, 0, 0, 3'b000, 3'b000, 9, 1, 8'd1, 3'b000, 3'b000, 3'b010));
    vq.push_back(mk(0, 0, 0, 0, 0, 3'b000, 3'b000, 3, 1, 8'd0, 3'b000, 3'b000, 3'b010));
    vq.push_back(mk(0, 0, 0, 0, 0, 3'b000, 3'b000, 3, 1, 8'd0, 3'b010, 3'b010, 3'b000));
    vq.push_back(mk(0, 0, 0, 0, 0, 3'b000, 3'b000, 1, 1, 8'd0, 3'b000, 3'b010, 3'b000));
    vq.push_back(mk(0, 0, 0, 0, 0, 3'b000, 3'b000, 5, 1, 8'd0, 3'b000, 3'b010, 3'b000));

    @(negedge clk);
    foreach (vq[v]) begin
      cyc(vq[v].rst, vq[v].we, vq[v].ch, vq[v].reload, vq[v].presc, vq[v].mode, vq[v].clr);
      if (vq[v].n > 1) idle(vq[v].n - 1);
      chk($sformatf("vec%0d.count", v), 64'(cnt_of(vq[v].cc)), 64'(vq[v].cnt));
      chk($sformatf("vec%0d.tc_pulse", v), 64'(tc_pulse), 64'(vq[v].tc));
      chk($sformatf("vec%0d.irq", v), 64'(irq), 64'(vq[v].irq));
      chk($sformatf("vec%0d.active", v), 64'(active), 64'(vq[v].act));
    end

    // Reconfigure ch2 on its terminal-tick cycle
    cyc(0, 1, 2, 8'd2, 8'd0, 3'b111, 3'b000);
    idle(2);
    chk("recfg.pre_count", 64'(cnt_of(2)), 64'd2);
    cyc(0, 1, 2, 8'd4, 8'd1, 3'b110, 3'b000);
    chk("recfg.count", 64'(cnt_of(2)), 64'd4);
    chk("recfg.tc", 64'(tc_pulse[2]), 64'd0);
    chk("recfg.irq", 64'(irq[2]), 64'd0);
    chk("recfg.active", 64'(active[2]), 64'd1);
    idle(1);
    chk("recfg.p_zero_hold", 64'(cnt_of(2)), 64'd4);
    idle(1);
    chk("recfg.first_step", 64'(cnt_of(2)), 64'd3);

    // Reset while every channel runs, then stay idle until configured
    cyc(0, 1, 0, 8'd3, 8'd0, 3'b111, 3'b000);
    cyc(0, 1, 1, 8'd3, 8'd0, 3'b111, 3'b000);
    chk("rst.pre_active", 64'(active), 64'b111);
    cyc(1, 1, 0, 8'd7, 8'd0, 3'b111, 3'b111);
    chk("rst.count", 64'(count), 64'd0);
    chk("rst.tc", 64'(tc_pulse), 64'd0);
    chk("rst.irq", 64'(irq), 64'd0);
    chk("rst.active", 64'(active), 64'd0);
    idle(5);
    chk("rst.hold_count", 64'(count), 64'd0);
    chk("rst.hold_active", 64'(active), 64'd0);
    cyc(0, 1, 3, 8'd5, 8'd0, 3'b111, 3'b000);
    idle(2);
    chk("oor.active", 64'(active), 64'd0);
    chk("oor.count", 64'(count), 64'd0);

    // Full-scale up count wraps through FF
    cyc(0, 1, 0, 8'hFF, 8'd0, 3'b111, 3'b000);
    idle(254);
    chk("wrap.fe", 64'(cnt_of(0)), 64'hFE);
    idle(1);
    chk("wrap.ff", 64'(cnt_of(0)), 64'hFF);
    chk("wrap.ff_tc", 64'(tc_pulse[0]), 64'd0);
    idle(1);
    chk("wrap.zero", 64'(cnt_of(0)), 64'h00);
    chk("wrap.tc", 64'(tc_pulse[0]), 64'd1);
    chk("wrap.irq", 64'(irq[0]), 64'd1);

    // reload=0 with presc=1, down: terminal every second cycle
    cyc(0, 1, 1, 8'd0, 8'd1, 3'b110, 3'b000);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      chk($sformatf("r0p1.tc%0d", k), 64'(tc_pulse[1]), 64'(k % 2));
      chk($sformatf("r0p1.cnt%0d", k), 64'(cnt_of(1)), 64'd0);
    end

    // reload=0 with presc=0: terminal on every cycle
    cyc(0, 1, 2, 8'd0, 8'd0, 3'b111, 3'b000);
    chk("r0.cfg_tc", 64'(tc_pulse[2]), 64'd0);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      chk($sformatf("r0.tc%0d", k), 64'(tc_pulse[2]), 64'd1);
      chk($sformatf("r0.cnt%0d", k), 64'(cnt_of(2)), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/counter_bank.md
COUNTER_BANK -- requirements
Module: counter_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning count/reload width in bits (2..64).
REQ-002 The block SHALL have parameter NUM_CH, default 4, meaning number of independent counter channels (1..16).
REQ-003 The block SHALL have parameter PRESC_W, default 8, meaning prescaler field width in bits.
REQ-004 The block SHALL have port clk  input  1  meaning the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst  input  1  meaning the reset, which is synchronous and active-high.
REQ-006 The block SHALL have port cfg_we  input  1  meaning write a configuration to channel cfg_ch.
REQ-007 The block SHALL have port cfg_ch  input  $clog2(NUM_CH) (min 1)  meaning the target channel index.
REQ-008 The block SHALL have port cfg_reload  input  WIDTH  meaning the reload/terminal value.
REQ-009 The block SHALL have port cfg_presc  input  PRESC_W  meaning the tick divisor minus one.
REQ-010 The block SHALL have port cfg_mode  input  3  meaning [0] up=1/down=0, [1] auto-reload=1/one-shot=0, [2] enable.
REQ-011 The block SHALL have port irq_clr  input  NUM_CH  meaning per-channel sticky flag clear.
REQ-012 The block SHALL have port count  output  NUM_CH*WIDTH  meaning channel i count on bits [i*WIDTH +: WIDTH].
REQ-013 The block SHALL have port tc_pulse  output  NUM_CH  meaning a one-cycle terminal-count strobe.
REQ-014 The block SHALL have port irq  output  NUM_CH  meaning a sticky terminal-count flag.
REQ-015 The block SHALL have port active  output  NUM_CH  meaning the channel is in state RUN.

Function
REQ-016 Each channel SHALL hold registered reload, presc, mode, a PRESC_W prescaler counter p, and a state in {IDLE, RUN, DONE}.
REQ-017 The start value SHALL be 0 when up=1 and reload when up=0; the terminal value SHALL be reload when up=1 and 0 when up=0.
REQ-018 On an edge with cfg_we=1, channel cfg_ch SHALL latch reload/presc/mode, set count to the start value, set p=0, clear tc_pulse, and enter RUN if enable=1, else IDLE.
REQ-019 An out-of-range cfg_ch (>= NUM_CH) SHALL be ignored.
REQ-020 In RUN, a tick SHALL occur on each edge where p==presc; at a tick p<=0, otherwise p<=p+1; presc=0 SHALL give a tick every cycle.
REQ-021 At a tick with count != terminal, count SHALL step by +1 (up) or -1 (down), modulo 2^WIDTH.
REQ-022 At a tick with count == terminal, tc_pulse[i] SHALL be 1 for exactly the following cycle and irq[i] SHALL be set.
REQ-023 At that terminal tick, an auto-reload channel SHALL set count to the start value and stay in RUN (period = (reload+1)*(presc+1) cycles).
REQ-024 At that terminal tick, a one-shot channel SHALL hold count at terminal and enter DONE.
REQ-025 With reload=0, every tick SHALL be a terminal tick.
REQ-026 In IDLE and DONE, count and p SHALL hold and no ticks SHALL occur; only cfg_we SHALL leave these states.
REQ-027 When cfg_we targets a channel in the same cycle as its tick, cfg_we SHALL win: no step and no tc_pulse/irq from that tick.
REQ-028 irq_clr[i]=1 SHALL clear irq[i] on the next edge, except that a simultaneous terminal tick on channel i SHALL leave irq[i]=1 (set wins).
REQ-029 Channels SHALL be fully independent; configuring one SHALL NOT disturb another.
REQ-030 active[i] SHALL equal (state==RUN) registered with the state, with no extra latency.

Reset
REQ-031 On an edge with rst=1, every channel SHALL get count=0, p=0, reload=0, presc=0, mode=0, state=IDLE, tc_pulse=0, irq=0, active=0, overriding cfg_we and irq_clr.
REQ-032 Asserting rst mid-count SHALL abort all channels; after release, the channels SHALL stay IDLE until reconfigured.

Verification
REQ-033 Up auto-reload test: ch0 with reload=3, presc=0, mode=3'b111 -> count 0,1,2,3,0,...; tc_pulse[0] every 4 cycles, 1 cycle wide; irq[0] stays set.
REQ-034 Down one-shot test: ch1 with reload=5, presc=2, mode=3'b100 -> count decrements every 3 cycles to 0; one tc_pulse; active[1] drops; count holds 0.
REQ-035 Clear-versus-set test: irq_clr[0]=1 in the same cycle as a terminal tick -> irq[0] stays 1; irq_clr one cycle later -> irq[0]=0.
REQ-036 Reconfigure-on-tick test: cfg_we to ch2 on its terminal-tick cycle -> no tc_pulse, count = new start value, p=0.
REQ-037 Reset test: rst=1 for 1 cycle while all channels are running -> all outputs 0 next cycle; no counting until cfg_we.
REQ-038 Boundary test: WIDTH=8, reload=8'hFF, up -> step 8'hFE->8'hFF then terminal wrap to 0; reload=0 -> tc_pulse on every tick.
